// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and FETCH/EXEC sequencing for the Harvard MIPS core.
// Latency: one instruction per 2 unstalled cycles; a taken target reaches pc once the delay slot's EXEC ends.
// Backpressure: stall=1 freezes state, pc and the pending target; HALT ignores all inputs until reset.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned commit target -> HALT with fault=1).
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] reg_target,
  input  logic [25:0] instr_index,
  input  logic [15:0] branch_offset,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8,
  output logic        state,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } seq_state_e;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_REG  = 2'b01;
  localparam logic [1:0] SEL_PAGE = 2'b10;
  localparam logic [1:0] SEL_REL  = 2'b11;

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;       // deferred branch/jump target
  logic        pend_vld_q, pend_vld_d; // a target waits for the delay slot to finish
  logic [31:0] pc_plus4;
  logic [31:0] rel_offset;
  logic [31:0] target;

  assign pc_plus4   = pc_q + 32'd4;
  assign rel_offset = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  // Resolve the target of the instruction currently in EXEC.
  always_comb begin
    target = 32'h0;
    case (jump_sel)
      SEL_REG:  target = reg_target;
      SEL_PAGE: target = {pc_plus4[31:28], instr_index, 2'b00};
      SEL_REL:  target = pc_plus4 + rel_offset;
      default:  target = 32'h0;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q, fault_d;
`endif

  // Next-state logic: advance phase, defer targets by one instruction, detect halt.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
`ifdef PC_ALIGN_CHECK_EN
    fault_d    = fault_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (!stall) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (pend_vld_q) begin
            // Delay slot done: commit the deferred target; jump_sel is ignored here.
            pend_vld_d = 1'b0;
            pend_d     = 32'h0;
            if (pend_q == 32'h0) begin
              state_d = S_HALT;
              pc_d    = 32'h0;
            end
`ifdef PC_ALIGN_CHECK_EN
            else if (pend_q[1:0] != 2'b00) begin
              // pc keeps the delay-slot address so the offending jump can be located.
              state_d = S_HALT;
              fault_d = 1'b1;
            end
`endif
            else begin
              state_d = S_FETCH;
              pc_d    = pend_q;
            end
          end else begin
            state_d = S_FETCH;
            pc_d    = pc_plus4;
            if (jump_sel != SEL_NONE) begin
              pend_d     = target;
              pend_vld_d = 1'b1;
            end
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Sequencer state registers; reset discards any pending target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 32'h0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign pc       = pc_q;
  assign pc_plus8 = pc_q + 32'd8;
  assign state    = (state_q == S_EXEC);
  assign active   = (state_q != S_HALT);

endmodule
